// File: rtl/rvee_rf_pkg.sv
// Shared types and helpers for the RVee multi-port register file.
package rvee_rf_pkg;

  localparam int RF_XLEN = 32;
  localparam int RF_RW   = 5;

  typedef logic [RF_XLEN-1:0] rf_word_t;
  typedef logic [RF_RW-1:0]   rf_idx_t;

  typedef enum logic {RF_CLEAR, RF_READY} rf_clr_state_e;

  // An index names a stored register only when it is below the register count
  function automatic logic rf_idx_valid(input logic [31:0] idx, input int unsigned n_regs);
    return (idx < n_regs);
  endfunction

endpackage

// File: rtl/rvee_rf_clr_fsm.sv
// Post-reset clear sequencer: zeroes R[1..N_REGS-1] one entry per cycle, then raises ready.
module rvee_rf_clr_fsm
  import rvee_rf_pkg::*;
#(
  parameter int N_REGS    = 32,
  parameter bit ZERO_INIT = 1'b1,
  localparam int IW       = $clog2(N_REGS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic          o_ready,
  output logic          o_clr_we,
  output logic [IW-1:0] o_clr_idx
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N_REGS - 1);

  rf_clr_state_e r_state, w_state_nxt;
  logic [IW-1:0] r_clr_idx, w_clr_idx_nxt;

  // State and clear pointer; reset restarts the sweep at x1 (x0 is never stored)
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state   <= RF_CLEAR;
      r_clr_idx <= IW'(1);
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  // Next state: leave CLEAR after the last entry is written, or at once without zero-init
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      RF_CLEAR: begin
        if (ZERO_INIT == 1'b0 || r_clr_idx == LAST_IDX) w_state_nxt = RF_READY;
        else                                             w_clr_idx_nxt = r_clr_idx + 1'b1;
      end
      default: w_state_nxt = RF_READY;
    endcase
  end

  // Outputs: clear write strobe only outside reset so a held reset writes nothing
  always_comb begin
    o_ready   = (r_state == RF_READY);
    o_clr_we  = (r_state == RF_CLEAR) && (ZERO_INIT != 1'b0) && i_rst;
    o_clr_idx = r_clr_idx;
  end

endmodule

// File: rtl/rvee_rf_mp.sv
// Multi-port integer register file with write/forward bypass and load-use pending scoreboard.
module rvee_rf_mp
  import rvee_rf_pkg::*;
#(
  parameter int XLEN      = RF_XLEN,
  parameter int N_REGS    = 32,
  parameter int N_RD      = 2,
  parameter int N_WR      = 1,
  parameter int N_FW      = 2,
  parameter bit ZERO_INIT = 1'b1,
  parameter int RW        = $clog2(N_REGS)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  output logic                           o_ready,
  input  logic [N_RD-1:0][RW-1:0]        i_rs,
  output logic [N_RD-1:0][XLEN-1:0]      o_rs_data,
  output logic [N_RD-1:0]                o_rs_busy,
  input  logic [N_WR-1:0]                i_wr_we,
  input  logic [N_WR-1:0][RW-1:0]        i_wr_rd,
  input  logic [N_WR-1:0][XLEN-1:0]      i_wr_data,
  input  logic [N_FW-1:0]                i_fw_vld,
  input  logic [N_FW-1:0][RW-1:0]        i_fw_rd,
  input  logic [N_FW-1:0][XLEN-1:0]      i_fw_data,
  input  logic                           i_pend_set,
  input  logic [RW-1:0]                  i_pend_rd
);

  localparam int IW = $clog2(N_REGS);

  logic [XLEN-1:0]   r_regs [N_REGS];
  logic [N_REGS-1:0] r_pend;

  logic              w_clr_we;
  logic [IW-1:0]     w_clr_idx;
  logic [N_WR-1:0]   w_wr_ok;
  logic              w_pend_ok;

  // Index names a stored, non-zero register
  function automatic logic f_idx_ok(input logic [RW-1:0] idx);
    return rf_idx_valid(32'(idx), N_REGS) && (idx != '0);
  endfunction

  rvee_rf_clr_fsm #(
    .N_REGS    (N_REGS),
    .ZERO_INIT (ZERO_INIT)
  ) u_clr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .o_ready   (o_ready),
    .o_clr_we  (w_clr_we),
    .o_clr_idx (w_clr_idx)
  );

  // Qualify write ports and pend request: gated by ready, x0 and out-of-range dropped
  always_comb begin
    for (int p = 0; p < N_WR; p++)
      w_wr_ok[p] = o_ready && i_wr_we[p] && f_idx_ok(i_wr_rd[p]);
    w_pend_ok = o_ready && i_pend_set && f_idx_ok(i_pend_rd);
  end

  // Array write: clear sweep owns the port until ready; later ports override earlier ones
  always_ff @(posedge i_clk) begin
    if (w_clr_we) begin
      r_regs[w_clr_idx] <= '0;
    end else begin
      for (int p = 0; p < N_WR; p++)
        if (w_wr_ok[p]) r_regs[i_wr_rd[p][IW-1:0]] <= i_wr_data[p];
    end
  end

  // Scoreboard: writeback clears, load issue sets; set is applied last so it wins
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_pend <= '0;
    end else begin
      for (int p = 0; p < N_WR; p++)
        if (w_wr_ok[p]) r_pend[i_wr_rd[p][IW-1:0]] <= 1'b0;
      if (w_pend_ok) r_pend[i_pend_rd[IW-1:0]] <= 1'b1;
    end
  end

  // Read ports: array, then fw stages (stage 0 youngest wins), then write ports (highest wins)
  always_comb begin : p_read
    logic hit;
    o_rs_data = '0;
    o_rs_busy = '0;
    hit       = 1'b0;
    for (int i = 0; i < N_RD; i++) begin
      hit = 1'b0;
      if (o_ready && f_idx_ok(i_rs[i])) begin
        o_rs_data[i] = r_regs[i_rs[i][IW-1:0]];
        for (int s = N_FW-1; s >= 0; s--)
          if (i_fw_vld[s] && i_fw_rd[s] == i_rs[i]) o_rs_data[i] = i_fw_data[s];
        for (int p = 0; p < N_WR; p++)
          if (i_wr_we[p] && i_wr_rd[p] == i_rs[i]) begin
            o_rs_data[i] = i_wr_data[p];
            hit          = 1'b1;
          end
        o_rs_busy[i] = r_pend[i_rs[i][IW-1:0]] && !hit;
      end
    end
  end

endmodule

// File: tb/tb_rvee_rf_mp.sv
// Self-checking bench for rvee_rf_mp: directed scenarios plus randomized traffic vs a reference model.
module tb_rvee_rf_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance: 32 regs, 2 read, 2 write, 2 fw stages, zero-init
  logic             rst;
  logic             ready;
  logic [1:0][4:0]  rs;
  logic [1:0][31:0] rs_data;
  logic [1:0]       rs_busy;
  logic [1:0]       wr_we;
  logic [1:0][4:0]  wr_rd;
  logic [1:0][31:0] wr_data;
  logic [1:0]       fw_vld;
  logic [1:0][4:0]  fw_rd;
  logic [1:0][31:0] fw_data;
  logic             pend_set;
  logic [4:0]       pend_rd;

  // RV32E instance: 16 regs, 5-bit indices so out-of-range names are expressible
  logic             e_rst;
  logic             e_ready;
  logic [1:0][4:0]  e_rs;
  logic [1:0][31:0] e_rs_data;
  logic [1:0]       e_rs_busy;
  logic [0:0]       e_wr_we;
  logic [0:0][4:0]  e_wr_rd;
  logic [0:0][31:0] e_wr_data;
  logic [0:0]       e_fw_vld;
  logic [0:0][4:0]  e_fw_rd;
  logic [0:0][31:0] e_fw_data;
  logic             e_pend_set;
  logic [4:0]       e_pend_rd;

  rvee_rf_mp #(.N_REGS(32), .N_RD(2), .N_WR(2), .N_FW(2), .ZERO_INIT(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .o_ready(ready),
    .i_rs(rs), .o_rs_data(rs_data), .o_rs_busy(rs_busy),
    .i_wr_we(wr_we), .i_wr_rd(wr_rd), .i_wr_data(wr_data),
    .i_fw_vld(fw_vld), .i_fw_rd(fw_rd), .i_fw_data(fw_data),
    .i_pend_set(pend_set), .i_pend_rd(pend_rd)
  );

  rvee_rf_mp #(.N_REGS(16), .N_RD(2), .N_WR(1), .N_FW(1), .ZERO_INIT(1'b0), .RW(5)) dut_e (
    .i_clk(clk), .i_rst(e_rst), .o_ready(e_ready),
    .i_rs(e_rs), .o_rs_data(e_rs_data), .o_rs_busy(e_rs_busy),
    .i_wr_we(e_wr_we), .i_wr_rd(e_wr_rd), .i_wr_data(e_wr_data),
    .i_fw_vld(e_fw_vld), .i_fw_rd(e_fw_rd), .i_fw_data(e_fw_data),
    .i_pend_set(e_pend_set), .i_pend_rd(e_pend_rd)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state (main instance, valid once ready)
  logic [31:0] m_R [32];
  bit          m_pend [32];

  function automatic void m_clear();
    for (int r = 0; r < 32; r++) begin m_R[r] = '0; m_pend[r] = 1'b0; end
  endfunction

  // read value: x0 -> 0, else newest writeback port, else youngest fw stage, else stored value
  function automatic logic [31:0] m_read(input int r);
    if (r == 0) return '0;
    for (int p = 1; p >= 0; p--) if (wr_we[p] && int'(wr_rd[p]) == r) return wr_data[p];
    for (int s = 0; s < 2; s++)  if (fw_vld[s] && int'(fw_rd[s]) == r) return fw_data[s];
    return m_R[r];
  endfunction

  function automatic bit m_busy(input int r);
    bit wb;
    wb = (wr_we[0] && int'(wr_rd[0]) == r) || (wr_we[1] && int'(wr_rd[1]) == r);
    return (r != 0) && m_pend[r] && !wb;
  endfunction

  function automatic void m_commit();
    for (int p = 0; p < 2; p++)
      if (wr_we[p] && wr_rd[p] != 0) begin m_R[wr_rd[p]] = wr_data[p]; m_pend[wr_rd[p]] = 1'b0; end
    if (pend_set && pend_rd != 0) m_pend[pend_rd] = 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic step();
    m_commit();
    tick();
  endtask

  task automatic idle();
    wr_we = '0; fw_vld = '0; pend_set = 1'b0;
  endtask

  task automatic test_reset();
    int rose;
    idle(); rst = 1'b0; rs[0] = 5'd5; rs[1] = 5'd0;
    repeat (3) tick();
    rst = 1'b1;
    // traffic during the clear must be ignored
    wr_we = 2'b01; wr_rd[0] = 5'd5; wr_data[0] = 32'hDEAD; pend_set = 1'b1; pend_rd = 5'd5;
    #1;
    n_cmp++; if (rs_data[0] !== 32'h0) begin n_bad++; $display("FAIL rst_read_x5 got %h exp 0", rs_data[0]); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b exp 0", ready); end
    rose = 0;
    for (int k = 1; k <= 100 && rose == 0; k++) begin
      tick();
      if (ready === 1'b1) rose = k;
      else if (rs_data[0] !== 32'h0 || rs_busy[0] !== 1'b0) begin
        n_cmp++; n_bad++; $display("FAIL rst_clear_read cyc %0d got %h/%b exp 0/0", k, rs_data[0], rs_busy[0]);
      end
    end
    idle();
    n_cmp++; if (rose !== 31) begin n_bad++; $display("FAIL rst_ready_latency got %0d exp 31", rose); end
    m_clear();
    for (int r = 1; r < 32; r++) begin
      rs[0] = 5'(r); rs[1] = 5'(32 - r); #1;
      n_cmp++; if (rs_data[0] !== 32'h0 || rs_data[1] !== 32'h0) begin
        n_bad++; $display("FAIL rst_zero x%0d got %h/%h exp 0", r, rs_data[0], rs_data[1]); end
      n_cmp++; if (rs_busy !== 2'b00) begin n_bad++; $display("FAIL rst_busy x%0d got %b exp 00", r, rs_busy); end
      tick();
    end
  endtask

  task automatic test_fw_priority();
    idle();
    wr_we = 2'b01; wr_rd[0] = 5'd7; wr_data[0] = 32'hAAAA;
    fw_vld = 2'b11; fw_rd[0] = 5'd7; fw_data[0] = 32'hBBBB; fw_rd[1] = 5'd7; fw_data[1] = 32'hCCCC;
    rs[0] = 5'd7; #1;
    n_cmp++; if (rs_data[0] !== 32'hAAAA) begin n_bad++; $display("FAIL fw_wr_first got %h exp AAAA", rs_data[0]); end
    step(); wr_we = '0; #1;
    n_cmp++; if (rs_data[0] !== 32'hBBBB) begin n_bad++; $display("FAIL fw_stage0 got %h exp BBBB", rs_data[0]); end
    fw_vld = 2'b10; #1;
    n_cmp++; if (rs_data[0] !== 32'hCCCC) begin n_bad++; $display("FAIL fw_stage1 got %h exp CCCC", rs_data[0]); end
    fw_vld = 2'b00; #1;
    n_cmp++; if (rs_data[0] !== 32'hAAAA) begin n_bad++; $display("FAIL fw_array got %h exp AAAA", rs_data[0]); end
    tick();
  endtask

  task automatic test_multi_write();
    idle();
    wr_we = 2'b11; wr_rd[0] = 5'd3; wr_data[0] = 32'd1; wr_rd[1] = 5'd3; wr_data[1] = 32'd2;
    rs[1] = 5'd3; #1;
    n_cmp++; if (rs_data[1] !== 32'd2) begin n_bad++; $display("FAIL mw_bypass got %h exp 2", rs_data[1]); end
    step(); idle(); #1;
    n_cmp++; if (rs_data[1] !== 32'd2) begin n_bad++; $display("FAIL mw_stored got %h exp 2", rs_data[1]); end
    wr_we = 2'b01; wr_rd[0] = 5'd0; wr_data[0] = 32'hFFFF; rs[0] = 5'd0; #1;
    n_cmp++; if (rs_data[0] !== 32'h0) begin n_bad++; $display("FAIL x0_bypass got %h exp 0", rs_data[0]); end
    step(); idle(); #1;
    n_cmp++; if (rs_data[0] !== 32'h0) begin n_bad++; $display("FAIL x0_stored got %h exp 0", rs_data[0]); end
    tick();
  endtask

  task automatic test_scoreboard();
    idle();
    pend_set = 1'b1; pend_rd = 5'd9; step(); idle(); rs[0] = 5'd9; #1;
    n_cmp++; if (rs_busy[0] !== 1'b1) begin n_bad++; $display("FAIL sb_set got %b exp 1", rs_busy[0]); end
    fw_vld = 2'b01; fw_rd[0] = 5'd9; fw_data[0] = 32'h777; step(); fw_vld = '0; #1;
    n_cmp++; if (rs_busy[0] !== 1'b1) begin n_bad++; $display("FAIL sb_fw_no_clear got %b exp 1", rs_busy[0]); end
    wr_we = 2'b10; wr_rd[1] = 5'd9; wr_data[1] = 32'h1234; #1;
    n_cmp++; if (rs_busy[0] !== 1'b0 || rs_data[0] !== 32'h1234) begin
      n_bad++; $display("FAIL sb_wb_mask got %b/%h exp 0/1234", rs_busy[0], rs_data[0]); end
    step(); idle(); #1;
    n_cmp++; if (rs_busy[0] !== 1'b0) begin n_bad++; $display("FAIL sb_cleared got %b exp 0", rs_busy[0]); end
    pend_set = 1'b1; pend_rd = 5'd9; wr_we = 2'b01; wr_rd[0] = 5'd9; wr_data[0] = 32'h5678;
    step(); idle(); #1;
    n_cmp++; if (rs_busy[0] !== 1'b1 || rs_data[0] !== 32'h5678) begin
      n_bad++; $display("FAIL sb_set_wins got %b/%h exp 1/5678", rs_busy[0], rs_data[0]); end
    pend_set = 1'b1; pend_rd = 5'd0; step(); idle(); rs[1] = 5'd0; #1;
    n_cmp++; if (rs_busy[1] !== 1'b0) begin n_bad++; $display("FAIL sb_x0 got %b exp 0", rs_busy[1]); end
    wr_we = 2'b01; wr_rd[0] = 5'd9; wr_data[0] = 32'h9; step(); idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        rs[i]      = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
        wr_rd[i]   = 5'($urandom_range(0, 7));
        fw_rd[i]   = 5'($urandom_range(0, 7));
        wr_data[i] = $urandom;
        fw_data[i] = $urandom;
      end
      wr_we    = 2'($urandom);
      fw_vld   = 2'($urandom);
      pend_set = ($urandom_range(0, 2) == 0);
      pend_rd  = 5'($urandom_range(0, 7));
      #1;
      for (int i = 0; i < 2; i++) begin
        n_cmp++; if (rs_data[i] !== m_read(int'(rs[i]))) begin
          n_bad++; $display("FAIL rnd_data it%0d p%0d x%0d got %h exp %h", n, i, rs[i], rs_data[i], m_read(int'(rs[i]))); end
        n_cmp++; if (rs_busy[i] !== m_busy(int'(rs[i]))) begin
          n_bad++; $display("FAIL rnd_busy it%0d p%0d x%0d got %b exp %b", n, i, rs[i], rs_busy[i], m_busy(int'(rs[i]))); end
      end
      step();
    end
    idle();
  endtask

  task automatic test_reset_mid_clear();
    int rose;
    idle(); pend_set = 1'b1; pend_rd = 5'd12; wr_we = 2'b01; wr_rd[0] = 5'd12; wr_data[0] = 32'h12;
    step(); idle(); rs[0] = 5'd12; #1;
    n_cmp++; if (rs_busy[0] !== 1'b1) begin n_bad++; $display("FAIL mid_pre_busy got %b exp 1", rs_busy[0]); end
    rst = 1'b0; tick(); rst = 1'b1;
    repeat (9) tick();
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL mid_ready_early got %b exp 0", ready); end
    rst = 1'b0; tick(); rst = 1'b1;
    rose = 0;
    for (int k = 1; k <= 100 && rose == 0; k++) begin
      tick();
      if (ready === 1'b1) rose = k;
    end
    n_cmp++; if (rose !== 31) begin n_bad++; $display("FAIL mid_ready_latency got %0d exp 31", rose); end
    m_clear();
    for (int r = 1; r < 32; r++) begin
      rs[0] = 5'(r); #1;
      n_cmp++; if (rs_busy[0] !== 1'b0 || rs_data[0] !== 32'h0) begin
        n_bad++; $display("FAIL mid_clean x%0d got %b/%h exp 0/0", r, rs_busy[0], rs_data[0]); end
      tick();
    end
  endtask

  task automatic test_rv32e();
    e_wr_we = '0; e_fw_vld = '0; e_pend_set = 1'b0; e_rs[0] = 5'd0; e_rs[1] = 5'd0;
    e_rst = 1'b0; tick(); tick(); e_rst = 1'b1; #1;
    n_cmp++; if (e_ready !== 1'b0) begin n_bad++; $display("FAIL e_ready_in_rst got %b exp 0", e_ready); end
    tick();
    n_cmp++; if (e_ready !== 1'b1) begin n_bad++; $display("FAIL e_ready_first got %b exp 1", e_ready); end
    e_wr_we = 1'b1; e_wr_rd[0] = 5'd4; e_wr_data[0] = 32'h44; tick();
    e_wr_rd[0] = 5'd15; e_wr_data[0] = 32'hF15; tick();
    e_wr_rd[0] = 5'd20; e_wr_data[0] = 32'h99; e_rs[0] = 5'd20; #1;
    n_cmp++; if (e_rs_data[0] !== 32'h0) begin n_bad++; $display("FAIL e_oor_bypass got %h exp 0", e_rs_data[0]); end
    tick(); e_wr_we = '0;
    e_pend_set = 1'b1; e_pend_rd = 5'd20; tick(); e_pend_set = 1'b0;
    e_rs[0] = 5'd4; e_rs[1] = 5'd20; #1;
    n_cmp++; if (e_rs_data[0] !== 32'h44) begin n_bad++; $display("FAIL e_x4_alias got %h exp 44", e_rs_data[0]); end
    n_cmp++; if (e_rs_data[1] !== 32'h0) begin n_bad++; $display("FAIL e_x20_read got %h exp 0", e_rs_data[1]); end
    n_cmp++; if (e_rs_busy !== 2'b00) begin n_bad++; $display("FAIL e_oor_pend got %b exp 00", e_rs_busy); end
    e_rs[0] = 5'd15; #1;
    n_cmp++; if (e_rs_data[0] !== 32'hF15) begin n_bad++; $display("FAIL e_x15 got %h exp F15", e_rs_data[0]); end
    tick();
  endtask

  initial begin
    rst = 1'b0; e_rst = 1'b0;
    rs = '0; wr_we = '0; wr_rd = '0; wr_data = '0; fw_vld = '0; fw_rd = '0; fw_data = '0;
    pend_set = 1'b0; pend_rd = '0;
    e_rs = '0; e_wr_we = '0; e_wr_rd = '0; e_wr_data = '0; e_fw_vld = '0; e_fw_rd = '0; e_fw_data = '0;
    e_pend_set = 1'b0; e_pend_rd = '0;
    m_clear();
    test_reset();
    test_fw_priority();
    test_multi_write();
    test_scoreboard();
    test_random();
    test_reset_mid_clear();
    test_rv32e();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
